// File: rtl/acc_fadd_scheduler.sv
// acc_fadd_scheduler: shares one FADD pipeline per accumulator among requesting cores,
// granting by signed stamp order with round-robin tie-break and tracking pipeline occupancy.
module acc_fadd_scheduler #(
    parameter int N_CORE   = 6,
    parameter int N_ACC    = 3,
    parameter int GC_WIDTH = 16,
    parameter int LATENCY  = 6,
    localparam int CW = $clog2(N_CORE),
    localparam int LW = $clog2(LATENCY + 1)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [N_CORE-1:0][N_ACC-1:0]               i_req_valid,
    output logic [N_CORE-1:0][N_ACC-1:0]               o_req_ready,
    input  logic [N_CORE-1:0][N_ACC-1:0][31:0]         i_req_data,
    input  logic [N_CORE-1:0][N_ACC-1:0][GC_WIDTH-1:0] i_req_stamp,
    input  logic                                       i_stamp_dir,
    output logic [N_ACC-1:0]                           o_disp_valid,
    output logic [N_ACC-1:0][CW-1:0]                   o_disp_core,
    output logic [N_ACC-1:0][31:0]                     o_disp_data,
    output logic [N_ACC-1:0]                           o_bypass_sel,
    output logic [N_ACC-1:0]                           o_result_we,
    output logic                                       o_all_idle,
    output logic                                       o_no_req
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    logic [N_ACC-1:0][LW-1:0] r_cnt;
    logic [N_ACC-1:0][LW-1:0] w_cnt_nxt;
    logic [N_ACC-1:0][CW-1:0] r_rr_ptr;
    logic [N_ACC-1:0][CW-1:0] w_rr_nxt;
    logic [N_ACC-1:0]         w_any;
    logic [N_ACC-1:0][CW-1:0] w_win;
    state_t                   w_state [N_ACC];

    // Winner search: scanning from rr_ptr and replacing only on a strictly better stamp
    // makes the first tied core in round-robin order win.
    always_comb begin
        int c;
        logic signed [GC_WIDTH-1:0] best;
        logic [CW-1:0] ci;
        w_any = '0;
        w_win = '0;
        c     = 0;
        best  = '0;
        ci    = '0;
        for (int a = 0; a < N_ACC; a++) begin
            best = '0;
            for (int k = 0; k < N_CORE; k++) begin
                c = int'(r_rr_ptr[a]) + k;
                if (c >= N_CORE) c = c - N_CORE;
                ci = CW'(c);
                if (i_req_valid[ci][a] && (!w_any[a] ||
                    (i_stamp_dir ? $signed(i_req_stamp[ci][a]) > best
                                 : $signed(i_req_stamp[ci][a]) < best))) begin
                    w_any[a] = 1'b1;
                    w_win[a] = ci;
                    best     = $signed(i_req_stamp[ci][a]);
                end
            end
        end
    end

    // Per-acc state from occupancy; grants, result strobes, status and next occupancy.
    always_comb begin
        o_req_ready  = '0;
        o_disp_valid = '0;
        o_disp_core  = '0;
        o_disp_data  = '0;
        o_result_we  = '0;
        o_bypass_sel = '0;
        o_all_idle   = 1'b1;
        o_no_req     = ~|i_req_valid;
        w_cnt_nxt    = r_cnt;
        w_rr_nxt     = r_rr_ptr;
        for (int a = 0; a < N_ACC; a++) begin
            w_state[a] = (r_cnt[a] == '0) ? S_IDLE :
                         (r_cnt[a] == LW'(1)) ? S_DRAIN : S_BUSY;
            o_disp_valid[a] = !reset && (w_state[a] != S_BUSY) && w_any[a];
            o_result_we[a]  = !reset && (w_state[a] == S_DRAIN);
            o_bypass_sel[a] = o_result_we[a];
            o_req_ready[w_win[a]][a] = o_disp_valid[a];
            o_disp_core[a]  = o_disp_valid[a] ? w_win[a] : '0;
            o_disp_data[a]  = o_disp_valid[a] ? i_req_data[w_win[a]][a] : '0;
            if (w_state[a] == S_BUSY) o_all_idle = 1'b0;
            w_cnt_nxt[a] = o_disp_valid[a] ? LW'(LATENCY) :
                           (w_state[a] == S_IDLE) ? '0 : r_cnt[a] - LW'(1);
            w_rr_nxt[a]  = !o_disp_valid[a] ? r_rr_ptr[a] :
                           (w_win[a] == CW'(N_CORE - 1)) ? '0 : w_win[a] + CW'(1);
        end
        if (reset) o_all_idle = 1'b1;
    end

    // Occupancy counters and round-robin pointers; reset drops in-flight ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end
endmodule

// File: tb/tb_acc_fadd_scheduler.sv
// tb_acc_fadd_scheduler: vector table, directed sequences and random traffic against a cycle-age reference model.
module tb_acc_fadd_scheduler;
    localparam int NC = 6, NA = 3, GW = 16, LAT = 6, BIG = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0][NA-1:0]         req_valid, req_ready;
    logic [NC-1:0][NA-1:0][31:0]   req_data;
    logic [NC-1:0][NA-1:0][GW-1:0] req_stamp;
    logic                          stamp_dir;
    logic [NA-1:0]                 disp_valid, bypass_sel, result_we;
    logic [NA-1:0][2:0]            disp_core;
    logic [NA-1:0][31:0]           disp_data;
    logic                          all_idle, no_req;

    acc_fadd_scheduler dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_data(req_data), .i_req_stamp(req_stamp), .i_stamp_dir(stamp_dir),
        .o_disp_valid(disp_valid), .o_disp_core(disp_core), .o_disp_data(disp_data),
        .o_bypass_sel(bypass_sel), .o_result_we(result_we),
        .o_all_idle(all_idle), .o_no_req(no_req)
    );

    int tests = 0, fails = 0;
    // model: age = cycles since last dispatch to the acc (BIG = none), rr = round-robin start
    int age [NA];
    int rr  [NA];
    logic [NC-1:0][NA-1:0] e_ready;
    logic [NA-1:0]         e_dv, e_rwe;
    logic [NA-1:0][2:0]    e_core;
    logic [NA-1:0][31:0]   e_data;
    logic                  e_idle, e_noreq;

    typedef struct packed {
        logic [1:0]        acc;
        logic              dir;
        logic [5:0]        m;
        logic [5:0][15:0]  st;
        logic [2:0]        exp;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(int c, int a);
        return 32'hA000_0000 | 32'(c * 16 + a);
    endfunction

    function automatic vec_t mk(int acc, bit dir, logic [5:0] m,
                                int s0, int s1, int s2, int s3, int s4, int s5, int e);
        vec_t v;
        v.acc = 2'(acc); v.dir = dir; v.m = m; v.exp = 3'(e);
        v.st  = {16'(s5), 16'(s4), 16'(s3), 16'(s2), 16'(s1), 16'(s0)};
        return v;
    endfunction

    task automatic model_eval();
        int best, win, s, c;
        bit any;
        e_ready = '0; e_dv = '0; e_rwe = '0; e_core = '0; e_data = '0;
        e_idle = 1'b1; e_noreq = 1'b1;
        for (int a = 0; a < NA; a++) begin
            any = 0; best = 0; win = 0;
            for (int cc = 0; cc < NC; cc++) if (req_valid[cc][a]) begin
                s = int'($signed(req_stamp[cc][a]));
                if (!any || (stamp_dir ? s > best : s < best)) best = s;
                any = 1; e_noreq = 1'b0;
            end
            for (int k = NC - 1; k >= 0; k--) begin
                c = (rr[a] + k) % NC;
                if (req_valid[c][a] && int'($signed(req_stamp[c][a])) == best) win = c;
            end
            if (age[a] < LAT) e_idle = 1'b0;
            if (!reset && age[a] >= LAT && any) begin
                e_dv[a] = 1'b1; e_core[a] = 3'(win);
                e_data[a] = req_data[win][a]; e_ready[win][a] = 1'b1;
            end
            e_rwe[a] = !reset && age[a] == LAT;
        end
        if (reset) e_idle = 1'b1;
    endtask

    task automatic model_update();
        for (int a = 0; a < NA; a++) begin
            if (reset) begin age[a] = BIG; rr[a] = 0; end
            else if (e_dv[a]) begin age[a] = 1; rr[a] = (int'(e_core[a]) + 1) % NC; end
            else if (age[a] < BIG) age[a]++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("m_ready", req_ready, e_ready);
        chk("m_disp_valid", disp_valid, e_dv);
        chk("m_disp_core", disp_core, e_core);
        chk("m_disp_data", disp_data, e_data);
        chk("m_result_we", result_we, e_rwe);
        chk("m_bypass_sel", bypass_sel, e_rwe);
        chk("m_all_idle", all_idle, e_idle);
        chk("m_no_req", no_req, e_noreq);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear();
        req_valid = '0; req_stamp = '0;
        for (int c = 0; c < NC; c++) for (int a = 0; a < NA; a++) req_data[c][a] = pat(c, a);
    endtask

    task automatic do_reset();
        reset = 1'b1; settle(); tick(); reset = 1'b0;
    endtask

    initial begin
        int g [4];
        g = '{0, 3, 5, 0};
        for (int a = 0; a < NA; a++) begin age[a] = BIG; rr[a] = 0; end
        stamp_dir = 1'b1;
        clear();
        req_valid[1][0] = 1'b1;
        req_valid[3][2] = 1'b1;
        settle();
        chk("rst_ready", req_ready, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_result_we", result_we, 0);
        chk("rst_all_idle", all_idle, 1);
        tick();
        reset = 1'b0;

        vt[0] = mk(0, 1, 6'b000100, 0, 0, 0, 0, 0, 0, 2);
        vt[1] = mk(1, 1, 6'b010010, 0, 5, 0, 0, 9, 0, 4);
        vt[2] = mk(1, 0, 6'b010010, 0, 5, 0, 0, 9, 0, 1);
        vt[3] = mk(2, 1, 6'b101001, 7, 0, 0, 7, 0, 7, 0);
        vt[4] = mk(0, 1, 6'b001010, 0, -3, 0, 2, 0, 0, 3);
        vt[5] = mk(0, 0, 6'b001010, 0, -3, 0, 2, 0, 0, 1);
        vt[6] = mk(2, 0, 6'b110000, 0, 0, 0, 0, -32768, 32767, 4);
        vt[7] = mk(1, 1, 6'b101001, 0, 0, 0, 1, 0, 1, 3);
        for (int i = 0; i < 8; i++) begin
            do_reset();
            clear();
            stamp_dir = vt[i].dir;
            for (int c = 0; c < NC; c++) if (vt[i].m[c]) begin
                req_valid[c][vt[i].acc] = 1'b1;
                req_stamp[c][vt[i].acc] = vt[i].st[c];
            end
            settle();
            chk($sformatf("vec%0d_core", i), disp_core[vt[i].acc], vt[i].exp);
            chk($sformatf("vec%0d_ready", i), req_ready[vt[i].exp][vt[i].acc], 1);
            chk($sformatf("vec%0d_data", i), disp_data[vt[i].acc], pat(int'(vt[i].exp), int'(vt[i].acc)));
            tick();
        end

        stamp_dir = 1'b1;
        do_reset(); clear();
        req_valid[2][0] = 1'b1; req_data[2][0] = 32'h3f80_0000;
        settle();
        chk("t1_ready", req_ready[2][0], 1);
        chk("t1_core", disp_core[0], 2);
        chk("t1_data", disp_data[0], 32'h3f80_0000);
        tick();
        req_valid = '0;
        for (int i = 1; i <= 7; i++) begin
            settle(); chk($sformatf("t1_we_c%0d", i), result_we[0], i == 6); tick();
        end

        do_reset(); clear();
        for (int c = 0; c < NC; c++) if (c == 0 || c == 3 || c == 5) begin
            req_valid[c][2] = 1'b1; req_stamp[c][2] = 16'd7;
        end
        for (int i = 0; i <= 18; i++) begin
            settle();
            chk($sformatf("t3_dv_c%0d", i), disp_valid[2], i % 6 == 0);
            if (i % 6 == 0) chk($sformatf("t3_core_c%0d", i), disp_core[2], g[i / 6]);
            tick();
        end

        do_reset(); clear();
        req_valid[0][0] = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            settle();
            chk($sformatf("t4_ready_c%0d", i), req_ready[0][0], i % 6 == 0);
            chk($sformatf("t4_we_c%0d", i), result_we[0], i % 6 == 0 && i > 0);
            chk($sformatf("t4_byp_c%0d", i), bypass_sel[0], i % 6 == 0 && i > 0);
            tick();
        end

        do_reset(); clear();
        req_valid[0][1] = 1'b1;
        settle(); tick();
        req_valid = '0;
        for (int i = 1; i <= 3; i++) begin settle(); tick(); end
        settle();
        chk("t5_busy", all_idle, 0);
        reset = 1'b1; settle(); tick(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t5_idle_c%0d", i), all_idle, 1);
            chk($sformatf("t5_we_c%0d", i), result_we[1], 0);
            tick();
        end

        do_reset(); clear();
        for (int a = 0; a < NA; a++) begin
            req_valid[1][a] = 1'b1; req_valid[2][a] = 1'b1;
            req_stamp[1][a] = 16'd4; req_stamp[2][a] = 16'd4;
        end
        settle();
        chk("t6_dv", disp_valid, 3'b111);
        chk("t6_core", disp_core, {3'd1, 3'd1, 3'd1});
        chk("t6_noreq0", no_req, 0);
        tick();
        clear();
        settle();
        chk("t6_noreq1", no_req, 1);
        tick();

        do_reset(); clear();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(99) == 0);
            if (n % 8 == 0) stamp_dir = 1'($urandom_range(1));
            settle();
            tick();
            for (int c = 0; c < NC; c++) for (int a = 0; a < NA; a++)
                if (!req_valid[c][a] || e_ready[c][a]) begin
                    req_valid[c][a] = ($urandom_range(9) < 3);
                    req_stamp[c][a] = 16'(int'($urandom_range(7)) - 4);
                    req_data[c][a]  = $urandom;
                end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
